// File: rtl/mem_access_unit_pkg.sv
// Shared types, sizes and helpers for the memory-stage access unit.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned OFFSET_W  = 16;
  localparam int unsigned DEST_W    = 5;
  localparam int unsigned RAM_DEPTH = 51;
  localparam int unsigned IO_ADDR   = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    MEM  = 2'd2,
    RESP = 2'd3
  } accessStateT;

  // Request fields captured on accept and held for the whole access.
  typedef struct packed {
    logic                isStore;
    logic [DATA_W-1:0]   base;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   storeData;
    logic [DEST_W-1:0]   dest;
  } reqFieldsT;

  // Sign-extend the 16-bit immediate offset to the data width.
  function automatic logic [DATA_W-1:0] signExtend(input logic [OFFSET_W-1:0] value);
    return {{(DATA_W - OFFSET_W){value[OFFSET_W-1]}}, value};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Execute-to-memory request/response bus.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_is_store;
  logic [DATA_W-1:0]   req_base;
  logic [OFFSET_W-1:0] req_offset;
  logic [DATA_W-1:0]   req_store_data;
  logic [DEST_W-1:0]   req_dest;
  logic                resp_valid;
  logic                resp_is_store;
  logic [DATA_W-1:0]   resp_load_data;
  logic [DEST_W-1:0]   resp_dest;
  logic                resp_fault;

  modport master (
    output req_valid, req_is_store, req_base, req_offset, req_store_data, req_dest,
    input  req_ready, resp_valid, resp_is_store, resp_load_data, resp_dest, resp_fault
  );

  modport slave (
    input  req_valid, req_is_store, req_base, req_offset, req_store_data, req_dest,
    output req_ready, resp_valid, resp_is_store, resp_load_data, resp_dest, resp_fault
  );

endinterface

// File: rtl/mem_access_unit_addr_check.sv
// Classifies a 32-bit effective address as RAM, the I/O word, or a fault.
module mem_addr_check
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] ea,
  output logic              inRange,
  output logic              ioHit,
  output logic              fault
);

  // Full-width compares so high bits can never alias into a legal address.
  always_comb begin
    inRange = (ea < DATA_W'(RAM_DEPTH));
    ioHit   = (ea == DATA_W'(IO_ADDR));
    fault   = !inRange && !ioHit;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load/store at a time, IDLE->ADDR->MEM->RESP.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  accessStateT       state;
  accessStateT       stateNext;
  reqFieldsT         req;
  logic [DATA_W-1:0] eaSum;
  logic              sumInRange;
  logic              sumIoHit;
  logic              sumFault;
  logic              inRange;
  logic              ioHit;
  logic              fault;
  logic              writeEnableReg;

  // Effective address, wrapping modulo 2^32.
  always_comb begin
    eaSum = req.base + signExtend(req.offset);
  end

  mem_addr_check addrCheck (
    .ea      (eaSum),
    .inRange (sumInRange),
    .ioHit   (sumIoHit),
    .fault   (sumFault)
  );

  // A reset landing on the MEM edge must suppress the RAM write.
  assign ram_write_enable = writeEnableReg && !reset;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.req_valid) stateNext = ADDR;
      ADDR:    stateNext = MEM;
      MEM:     stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request capture, address classification, RAM/I/O drive and response.
  always_ff @(posedge clock) begin
    if (reset) begin
      req                <= '0;
      inRange            <= 1'b0;
      ioHit              <= 1'b0;
      fault              <= 1'b0;
      ram_address        <= '0;
      ram_write_data     <= '0;
      writeEnableReg     <= 1'b0;
      io_out             <= '0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_is_store  <= 1'b0;
      bus.resp_load_data <= '0;
      bus.resp_dest      <= '0;
      bus.resp_fault     <= 1'b0;
    end else begin
      bus.req_ready  <= (stateNext == IDLE);
      bus.resp_valid <= (stateNext == RESP);
      writeEnableReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req.isStore   <= bus.req_is_store;
            req.base      <= bus.req_base;
            req.offset    <= bus.req_offset;
            req.storeData <= bus.req_store_data;
            req.dest      <= bus.req_dest;
          end
        end
        ADDR: begin
          inRange        <= sumInRange;
          ioHit          <= sumIoHit;
          fault          <= sumFault;
          ram_address    <= eaSum[ADDR_W-1:0];
          ram_write_data <= req.storeData;
          writeEnableReg <= req.isStore && sumInRange;
        end
        MEM: begin
          if (req.isStore && ioHit) begin
            io_out <= req.storeData;
          end
          bus.resp_is_store <= req.isStore;
          bus.resp_dest     <= req.dest;
          bus.resp_fault    <= fault;
          if (req.isStore) begin
            bus.resp_load_data <= '0;
          end else if (inRange) begin
            bus.resp_load_data <= ram_read_data;
          end else if (ioHit) begin
            bus.resp_load_data <= io_in;
          end else begin
            bus.resp_load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a combinational-read RAM model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data;
  logic [DATA_W-1:0] io_in = '0;
  logic [DATA_W-1:0] io_out;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data),
    .io_in            (io_in),
    .io_out           (io_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        isStore;
    logic [4:0]  dest;
    logic        fault;
    logic [31:0] load;
    int          cyc;
  } expT;

  expT         sb[$];
  logic [31:0] mem [0:1023];
  int          cycleCnt = 0;
  int          weCount = 0;
  logic [31:0] lastWeAddr = '0;
  logic [31:0] lastWeData = '0;
  int          checks = 0;
  int          passes = 0;

  assign ram_read_data = mem[ram_address];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // RAM model plus write and cycle bookkeeping.
  always @(posedge clock) begin
    cycleCnt <= cycleCnt + 1;
    if (ram_write_enable) begin
      mem[ram_address] <= ram_write_data;
      weCount    <= weCount + 1;
      lastWeAddr <= 32'(ram_address);
      lastWeData <= ram_write_data;
    end
  end

  // Response monitor: pops the scoreboard whenever a response appears.
  always @(negedge clock) begin
    if (!reset && bus.resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(bus.resp_dest), 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = sb.pop_front();
        chk("resp_is_store", 32'(bus.resp_is_store), 32'(e.isStore));
        chk("resp_dest", 32'(bus.resp_dest), 32'(e.dest));
        chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
        chk("resp_load_data", bus.resp_load_data, e.load);
        chk("resp_cycle", 32'(cycleCnt), 32'(e.cyc));
      end
    end
  end

  // Present a request at a negedge and return once it has been accepted.
  task automatic doReq(input logic isStore, input logic [31:0] base, input logic [15:0] offset,
                       input logic [31:0] data, input logic [4:0] dest, input logic expFault,
                       input logic [31:0] expLoad, input logic expectResp, output int waitCycles);
    expT e;
    bus.req_valid      = 1'b1;
    bus.req_is_store   = isStore;
    bus.req_base       = base;
    bus.req_offset     = offset;
    bus.req_store_data = data;
    bus.req_dest       = dest;
    waitCycles = 0;
    while (!bus.req_ready && waitCycles < 20) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(waitCycles), 32'd0);
    end else if (expectResp) begin
      e.isStore = isStore;
      e.dest    = dest;
      e.fault   = expFault;
      e.load    = expLoad;
      e.cyc     = cycleCnt + 3;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  // Drop req_valid and wait, bounded, for all outstanding responses.
  task automatic drain();
    int n;
    bus.req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) chk("resp_timeout", 32'(sb.size()), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int w;
    int we0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[20] = 32'd2;
    bus.req_valid      = 1'b0;
    bus.req_is_store   = 1'b0;
    bus.req_base       = '0;
    bus.req_offset     = '0;
    bus.req_store_data = '0;
    bus.req_dest       = '0;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_ram_we", 32'(ram_write_enable), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_io_out", io_out, 32'd0);
    @(negedge clock);

    // Load RAM[20] via base 18 + 2.
    we0 = weCount;
    doReq(1'b0, 32'd18, 16'd2, 32'd0, 5'd7, 1'b0, 32'd2, 1'b1, w);
    drain();
    chk("load_no_write", 32'(weCount - we0), 32'd0);

    // Store with negative offset: 10 - 4 = 6.
    we0 = weCount;
    doReq(1'b1, 32'd10, 16'hFFFC, 32'hDEAD_BEEF, 5'd1, 1'b0, 32'd0, 1'b1, w);
    drain();
    chk("store6_we_count", 32'(weCount - we0), 32'd1);
    chk("store6_we_addr", lastWeAddr, 32'd6);
    chk("store6_we_data", lastWeData, 32'hDEAD_BEEF);
    doReq(1'b0, 32'd6, 16'd0, 32'd0, 5'd3, 1'b0, 32'hDEAD_BEEF, 1'b1, w);
    drain();

    // Last legal word (ea 50).
    we0 = weCount;
    doReq(1'b1, 32'd40, 16'd10, 32'h1234_5678, 5'd2, 1'b0, 32'd0, 1'b1, w);
    drain();
    chk("store50_we_count", 32'(weCount - we0), 32'd1);
    chk("store50_mem", mem[50], 32'h1234_5678);
    doReq(1'b0, 32'd50, 16'd0, 32'd0, 5'd4, 1'b0, 32'h1234_5678, 1'b1, w);
    drain();

    // First illegal word (ea 51), high-bit alias, negative wrap.
    we0 = weCount;
    doReq(1'b1, 32'd51, 16'd0, 32'h0000_FFFF, 5'd12, 1'b1, 32'd0, 1'b1, w);
    drain();
    chk("store51_no_write", 32'(weCount - we0), 32'd0);
    chk("store51_mem", mem[51], 32'd0);
    doReq(1'b0, 32'd45, 16'd6, 32'd0, 5'd5, 1'b1, 32'd0, 1'b1, w);
    drain();
    doReq(1'b0, 32'h0000_0400, 16'd6, 32'd0, 5'd6, 1'b1, 32'd0, 1'b1, w);
    drain();
    doReq(1'b0, 32'd1, 16'hFFFE, 32'd0, 5'd8, 1'b1, 32'd0, 1'b1, w);
    drain();

    // Memory-mapped I/O word.
    we0 = weCount;
    doReq(1'b1, 32'd1000, 16'd23, 32'h0000_0055, 5'd13, 1'b0, 32'd0, 1'b1, w);
    drain();
    chk("io_store_out", io_out, 32'h0000_0055);
    chk("io_store_no_write", 32'(weCount - we0), 32'd0);
    io_in = 32'h0000_A5A5;
    doReq(1'b0, 32'd1023, 16'd0, 32'd0, 5'd9, 1'b0, 32'h0000_A5A5, 1'b1, w);
    drain();

    // Back-to-back with req_valid held: second accept waits for IDLE.
    doReq(1'b0, 32'd20, 16'd0, 32'd0, 5'd10, 1'b0, 32'd2, 1'b1, w);
    doReq(1'b0, 32'd50, 16'd0, 32'd0, 5'd11, 1'b0, 32'h1234_5678, 1'b1, w);
    chk("b2b_ready_low_cycles", 32'(w), 32'd3);
    drain();

    // Reset while a store sits in MEM.
    we0 = weCount;
    doReq(1'b1, 32'd0, 16'd30, 32'h0000_1234, 5'd14, 1'b0, 32'd0, 1'b0, w);
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("mem_we_before_reset", 32'(ram_write_enable), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_no_write", 32'(weCount - we0), 32'd0);
    chk("rst_mid_mem30", mem[30], 32'd0);
    chk("rst_mid_io_out", io_out, 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
